sipo_2bit_us: RTL and testbench
===============================

# sipo_2bit_us

Serial-in parallel-out collector for the radix-4 datapath: accepts 2 bits per beat, LSB-pair first, and assembles a W-bit word. It is the receiving end of the 2-bit-per-cycle shifting used by the Booth multiplier. It presents the completed word with a valid/ack handshake, so product digits retired 2 bits at a time can be reassembled into the parallel result. Frame control is a 3-state FSM with a beat counter.

## Interface
- W, default 16: assembled word width. Must be even and ≥4. BEATS = W/2 is a derived localparam.
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  opens a new frame; clears the collector and the beat count
- sin  input  2  serial data pair; sin[0] is the lower-weight bit
- sin_valid  input  1  sin is valid this cycle
- pout  output  W  assembled word; stable while pout_valid=1
- pout_valid  output  1  word complete; held until pout_ack
- pout_ack  input  1  consumer accepts pout
- busy  output  1  frame in progress (state SHIFT)
- overrun  output  1  sticky: a beat arrived while the word was unconsumed

## Operation
- Reset (rst=0, async): state=IDLE, shift register=0, count=0, pout=0, pout_valid=0, busy=0, overrun=0.
- States:
  - IDLE
    - start=1 → SHIFT; shift register=0; count=0; overrun=0.
    - sin_valid is ignored in IDLE, including when it coincides with start.
  - SHIFT (busy=1)
    - Each sin_valid cycle: shift register ← {sin, shift register[W-1:2]}; count++.
    - sin_valid on the beat where count==BEATS-1 → FULL, pout_valid=1.
    - start=1 in SHIFT: restart. Register and count clear; a coincident sin_valid beat is dropped; the state stays SHIFT.
  - FULL (pout_valid=1)
    - pout_ack=1 → IDLE.
    - pout_ack=1 with start=1 in the same cycle → SHIFT directly (back-to-back frames); register and count clear.
    - start without pout_ack is ignored.
    - sin_valid is never shifted in while in FULL.
- pout is the shift register itself. The first beat received ends up in pout[1:0]; the last in pout[W-1:W-2].
- Gaps in sin_valid are allowed; count advances only on valid beats.
- No arithmetic is performed; bits are stored unmodified.

## Timing
- Registered outputs only; no combinational input-to-output paths.
- pout_valid rises on the clock edge that captures beat BEATS-1, i.e. minimum latency is BEATS cycles from the first beat.
- busy rises on the edge that samples start in IDLE.
- busy falls on the same edge where pout_valid rises.
- pout_valid falls on the edge that samples pout_ack=1.
- Minimum frame period with continuous valid beats and same-cycle ack+start: BEATS+1 cycles.
- Reset asserted mid-frame clears everything immediately and asynchronously. After deassertion, a new start is required.

## Configuration
- SIPO_OVERRUN_EN defined:
  - sin_valid=1 while in FULL sets overrun on that edge.
  - overrun stays set until reset or until start is accepted, whether from IDLE or via FULL ack+start.
- SIPO_OVERRUN_EN undefined:
  - overrun is tied to 0.
  - Beats arriving in FULL are silently discarded.

## Test plan
- Basic frame (W=16): start, then beats 3,0,0,3,1,1,2,2 on consecutive cycles → pout=16'hA5C3 with pout_valid=1 after the 8th beat edge. busy is high for exactly 8 cycles.
- Gapped input: same 8 beats with sin_valid deasserted for 1–3 cycles between beats → same pout=16'hA5C3. pout_valid is held for 5 cycles until pout_ack.
- Restart mid-frame: 3 beats of 2'b11, then start with sin_valid=1 carrying 2'b10, then 8 beats of 2'b01 → pout=16'h5555. The beat coincident with start is dropped.
- Back-to-back: in FULL, assert pout_ack and start together → next cycle busy=1 and pout_valid=0. The second frame of 8 beats of 2'b10 gives pout=16'hAAAA.
- Reset mid-frame: drive rst=0 asynchronously between clock edges after 4 beats → all outputs 0 immediately. Beats after rst=1 without start are ignored.
- Overrun, with SIPO_OVERRUN_EN: one sin_valid in FULL → overrun=1 and pout unchanged. ack+start → overrun=0. Without the macro, overrun remains 0.

Source files
------------

// File: rtl/sipo_2bit_us.sv
// Serial-in parallel-out collector: 2 bits per beat, LSB pair first, W-bit word with valid/ack.
// Optional sticky overrun detection is built when SIPO_OVERRUN_EN is defined.
module sipo_2bit_us #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   sin,
  input  logic         sin_valid,
  output logic [W-1:0] pout,
  output logic         pout_valid,
  input  logic         pout_ack,
  output logic         busy,
  output logic         overrun
);

  localparam int BEATS = W / 2;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t         state_r;
  logic [W-1:0]   sr_r;
  logic [CW-1:0]  cnt_r;
  logic           pout_valid_r;
  logic           busy_r;
`ifdef SIPO_OVERRUN_EN
  logic           ovr_r;
`endif

  // Frame FSM: shift register, beat counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      sr_r         <= '0;
      cnt_r        <= '0;
      pout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef SIPO_OVERRUN_EN
      ovr_r        <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= SHIFT;
            sr_r    <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
`ifdef SIPO_OVERRUN_EN
            ovr_r   <= 1'b0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          // a restart drops any beat presented in the same cycle
          if (start) begin
            sr_r  <= '0;
            cnt_r <= '0;
          end else if (sin_valid) begin
            sr_r <= {sin, sr_r[W-1:2]};
            if (cnt_r == LAST) begin
              state_r      <= FULL;
              cnt_r        <= '0;
              pout_valid_r <= 1'b1;
              busy_r       <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CW'(1'b1);
            end
          end else begin
            state_r <= SHIFT;
          end
        end
        FULL: begin
          if (pout_ack) begin
            pout_valid_r <= 1'b0;
            if (start) begin
              state_r <= SHIFT;
              sr_r    <= '0;
              cnt_r   <= '0;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= FULL;
          end
`ifdef SIPO_OVERRUN_EN
          // accepted start clears the flag and takes priority over a coincident beat
          if (pout_ack && start) begin
            ovr_r <= 1'b0;
          end else if (sin_valid) begin
            ovr_r <= 1'b1;
          end else begin
            ovr_r <= ovr_r;
          end
`endif
        end
        default: begin
          state_r      <= IDLE;
          sr_r         <= '0;
          cnt_r        <= '0;
          pout_valid_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign pout       = sr_r;
  assign pout_valid = pout_valid_r;
  assign busy       = busy_r;
`ifdef SIPO_OVERRUN_EN
  assign overrun    = ovr_r;
`else
  assign overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_2bit_us.sv
// Bench for sipo_2bit_us (W=16): directed test-plan steps plus random traffic against a queue model.
module tb_sipo_2bit_us;

  localparam int W     = 16;
  localparam int BEATS = W / 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   sin;
  logic         sin_valid;
  logic [W-1:0] pout;
  logic         pout_valid;
  logic         pout_ack;
  logic         busy;
  logic         overrun;

  int tests;
  int fails;

  // model: received beats of the current frame, plus frame/full/overrun flags
  logic [1:0] q[$];
  bit         m_frame;
  bit         m_full;
  bit         m_ovr;

  sipo_2bit_us #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
    .pout(pout), .pout_valid(pout_valid), .pout_ack(pout_ack),
    .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word seen after k beats: beat i sits at bit 2*(BEATS-k+i)
  function automatic logic [W-1:0] exp_pout();
    logic [W-1:0] w;
    int k;
    w = '0;
    k = q.size();
    for (int i = 0; i < k; i++) begin
      w = w | (W'(q[i]) << (2 * (BEATS - k + i)));
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pout"}, pout, exp_pout());
    chk({tag, ".pout_valid"}, W'(pout_valid), W'(m_full));
    chk({tag, ".busy"}, W'(busy), W'(m_frame));
    chk({tag, ".overrun"}, W'(overrun), W'(m_ovr));
  endtask

  task automatic model_reset();
    q.delete();
    m_frame = 1'b0;
    m_full  = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check
  task automatic step(input bit st, input bit sv, input logic [1:0] s, input bit ak, input string tag);
    start = st; sin_valid = sv; sin = s; pout_ack = ak;
    @(posedge clk);
    if (m_frame) begin
      if (st) q.delete();
      else if (sv) begin
        q.push_back(s);
        if (q.size() == BEATS) begin
          m_frame = 1'b0;
          m_full  = 1'b1;
        end
      end
    end else if (m_full) begin
`ifdef SIPO_OVERRUN_EN
      if (sv && !(ak && st)) m_ovr = 1'b1;
`endif
      if (ak) begin
        m_full = 1'b0;
        if (st) begin
          m_frame = 1'b1;
          q.delete();
          m_ovr = 1'b0;
        end
      end
    end else if (st) begin
      m_frame = 1'b1;
      q.delete();
      m_ovr = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  logic [1:0] basic[8];
  bit         st_r, sv_r, ak_r;
  logic [1:0] s_r;

  initial begin
    tests = 0; fails = 0;
    basic = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    start = 1'b0; sin_valid = 1'b0; sin = 2'b00; pout_ack = 1'b0;
    rst = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    #10 rst = 1'b1;

    // basic frame on consecutive cycles
    step(1, 0, 2'd0, 0, "basic.start");
    for (int i = 0; i < 8; i++) step(0, 1, basic[i], 0, "basic.beat");
    chk("basic.word", pout, 16'hA5C3);
    step(0, 0, 2'd0, 1, "basic.ack");

    // gapped beats, valid held 5 cycles before ack
    step(1, 1, 2'd1, 0, "gap.start");
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 1 + (i % 3); g++) step(0, 0, 2'd3, 0, "gap.idle");
      step(0, 1, basic[i], 0, "gap.beat");
    end
    for (int h = 0; h < 4; h++) step(0, 0, 2'd0, 0, "gap.hold");
    chk("gap.word", pout, 16'hA5C3);
    step(0, 0, 2'd0, 1, "gap.ack");

    // restart mid-frame drops the coincident beat
    step(1, 0, 2'd0, 0, "rs.start");
    for (int i = 0; i < 3; i++) step(0, 1, 2'b11, 0, "rs.pre");
    step(1, 1, 2'b10, 0, "rs.restart");
    for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 0, "rs.beat");
    chk("rs.word", pout, 16'h5555);

    // back-to-back ack+start
    step(1, 0, 2'd0, 1, "b2b.ackstart");
    chk("b2b.busy", W'(busy), W'(1'b1));
    for (int i = 0; i < 8; i++) step(0, 1, 2'b10, 0, "b2b.beat");
    chk("b2b.word", pout, 16'hAAAA);

    // overrun: a beat while FULL, then cleared by ack+start
    step(0, 1, 2'b11, 0, "ovr.beat");
    chk("ovr.word", pout, 16'hAAAA);
    step(1, 0, 2'd0, 1, "ovr.ackstart");
    chk("ovr.cleared", W'(overrun), W'(1'b0));

    // reset mid-frame after 4 beats, between edges
    for (int i = 0; i < 4; i++) step(0, 1, basic[i], 0, "rst.beat");
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("rst.async");
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) step(0, 1, 2'b11, 0, "rst.ignored");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      st_r = ($urandom_range(0, 9) == 0);
      sv_r = ($urandom_range(0, 9) < 6);
      ak_r = ($urandom_range(0, 9) < 3);
      s_r  = 2'($urandom_range(0, 3));
      step(st_r, sv_r, s_r, ak_r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
